// File: rtl/add_sub_checker_if.sv
// ---------------------------------------------------------------------------
// add_sub_checker_if
// Operand/result bus between the add/sub checker and the unit under test.
//   A, B      : 8-bit operands presented to the unit
//   mode      : 0 = add, 1 = subtract
//   dut_sum   : 8-bit result returned by the unit
//   dut_cout  : carry (add) / borrow-not (subtract) returned by the unit
// Modports:
//   master : the checker (drives operands, receives the result)
//   slave  : the unit under test (receives operands, drives the result)
// ---------------------------------------------------------------------------
interface add_sub_checker_if;
    logic [7:0] A;
    logic [7:0] B;
    logic       mode;
    logic [7:0] dut_sum;
    logic       dut_cout;

    modport master (
        output A,
        output B,
        output mode,
        input  dut_sum,
        input  dut_cout
    );

    modport slave (
        input  A,
        input  B,
        input  mode,
        output dut_sum,
        output dut_cout
    );
endinterface

// File: rtl/add_sub_checker.sv
// ---------------------------------------------------------------------------
// add_sub_checker
// Built-in self-test engine for an 8-bit adder/subtractor. An LFSR produces
// NUM_VEC operand pairs, first in add mode and then (reseeded) in subtract
// mode. Each vector is held for SETTLE cycles, then checked for one cycle
// against the 9-bit expected {cout,sum}; mismatches are counted saturating.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : run request, honoured only in IDLE or DONE
//   uut        : operand/result bus (master side)
//   busy       : high while driving or checking vectors
//   done       : high when the run has completed
//   pass       : done with zero mismatches
//   err_count  : mismatch count, saturating at 8'hFF
//   fail_A/fail_B/fail_mode/fail_sum : first-failure capture
//
// Optional feature (macro ADD_SUB_CHK_CAPTURE_EN): when defined, the first
// mismatch of a run latches the operands, mode and expected {cout,sum} into
// fail_*; they hold until the next start or rst. When undefined, fail_* are
// tied to 0 and no capture registers exist.
// ---------------------------------------------------------------------------
module add_sub_checker #(
    parameter int         NUM_VEC = 16,
    parameter logic [7:0] SEED    = 8'h01,
    parameter int         SETTLE  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    add_sub_checker_if.master       uut,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              err_count,
    output logic [7:0]              fail_A,
    output logic [7:0]              fail_B,
    output logic                    fail_mode,
    output logic [8:0]              fail_sum
);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   lfsr;
    logic [DATA_W-1:0]   idx;
    logic [3:0]          settle_cnt;
    logic                mode_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [DATA_W:0]     exp_res;
    logic                mismatch;
    logic                settle_last;
    logic                vec_last;
    logic                start_ok;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [DATA_W-1:0] nib_swap(input logic [DATA_W-1:0] q);
        return {q[3:0], q[7:4]};
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Subtract as A + ~B + 1 so the carry out is the borrow-not (A >= B)
    function automatic logic [DATA_W:0] expected(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              m);
        if (m)
            return {1'b0, a} + {1'b0, ~b} + 9'd1;
        else
            return {1'b0, a} + {1'b0, b};
    endfunction

    assign exp_res     = expected(a_r, b_r, mode_r);
    assign mismatch    = ({uut.dut_cout, uut.dut_sum} != exp_res);
    assign settle_last = (settle_cnt == 4'(SETTLE - 1));
    assign vec_last    = (idx == 8'(NUM_VEC - 1));
    assign start_ok    = start && ((state == IDLE) || (state == DONE));

    assign uut.A    = a_r;
    assign uut.B    = b_r;
    assign uut.mode = mode_r;

    // Status is decoded from state so rst clears it without a clock edge
    assign busy = (state == DRIVE) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)       state_nxt = DRIVE;
            DRIVE:      if (settle_last) state_nxt = CHECK;
            CHECK:      state_nxt = (vec_last && mode_r) ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= SEED;
            a_r        <= '0;
            b_r        <= '0;
            mode_r     <= 1'b0;
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr       <= SEED;
                        a_r        <= SEED;
                        b_r        <= nib_swap(SEED);
                        mode_r     <= 1'b0;
                        idx        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch)
                        err_count <= sat_inc(err_count);
                    // Operands track the LFSR; on the final subtract vector they
                    // are left untouched so DONE shows the last pair.
                    if (vec_last) begin
                        if (!mode_r) begin
                            mode_r <= 1'b1;
                            lfsr   <= SEED;
                            a_r    <= SEED;
                            b_r    <= nib_swap(SEED);
                            idx    <= '0;
                        end
                    end else begin
                        lfsr <= lfsr_next(lfsr);
                        a_r  <= lfsr_next(lfsr);
                        b_r  <= nib_swap(lfsr_next(lfsr));
                        idx  <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADD_SUB_CHK_CAPTURE_EN
    logic [7:0] cap_a;
    logic [7:0] cap_b;
    logic       cap_mode;
    logic [8:0] cap_sum;

    // err_count still zero in CHECK means this is the first mismatch of the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a    <= '0;
            cap_b    <= '0;
            cap_mode <= 1'b0;
            cap_sum  <= '0;
        end else if (start_ok) begin
            cap_a    <= '0;
            cap_b    <= '0;
            cap_mode <= 1'b0;
            cap_sum  <= '0;
        end else if ((state == CHECK) && mismatch && (err_count == 8'd0)) begin
            cap_a    <= a_r;
            cap_b    <= b_r;
            cap_mode <= mode_r;
            cap_sum  <= exp_res;
        end
    end

    assign fail_A    = cap_a;
    assign fail_B    = cap_b;
    assign fail_mode = cap_mode;
    assign fail_sum  = cap_sum;
`else
    assign fail_A    = '0;
    assign fail_B    = '0;
    assign fail_mode = 1'b0;
    assign fail_sum  = '0;
`endif

endmodule

// File: tb/tb_add_sub_checker.sv
// ---------------------------------------------------------------------------
// tb_add_sub_checker
// Bench for add_sub_checker. Three instances share clk/rst:
//   u0 : defaults, correct unit model with optional bit-0 fault on dut_sum
//   u1 : SEED = 8'h80, correct unit model
//   u2 : NUM_VEC = 255, unit stuck at zero (saturating error count)
// Expected operand vectors are queued when a run is started and popped as
// each vector appears on the bus.
// ---------------------------------------------------------------------------
module tb_add_sub_checker;
    logic clk;
    logic rst;
    logic start0, start1, start2;
    logic inj_flip;

    logic       busy0, done0, pass0, fm0;
    logic [7:0] err0, fa0, fb0;
    logic [8:0] fs0;
    logic       busy1, done1, pass1, fm1;
    logic [7:0] err1, fa1, fb1;
    logic [8:0] fs1;
    logic       busy2, done2, pass2, fm2;
    logic [7:0] err2, fa2, fb2;
    logic [8:0] fs2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
    } vec_t;

    vec_t sb[$];

    add_sub_checker_if bus0();
    add_sub_checker_if bus1();
    add_sub_checker_if bus2();

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Reference adder/subtractor: subtract computed as a true difference
    function automatic logic [8:0] ref_unit(input logic [7:0] a, input logic [7:0] b,
                                            input logic m);
        logic [7:0] d;
        if (!m) return {1'b0, a} + {1'b0, b};
        d = a - b;
        return {(a >= b), d};
    endfunction

    logic [8:0] r0, r1;
    assign r0            = ref_unit(bus0.A, bus0.B, bus0.mode);
    assign bus0.dut_sum  = r0[7:0] ^ {7'b0, inj_flip};
    assign bus0.dut_cout = r0[8];
    assign r1            = ref_unit(bus1.A, bus1.B, bus1.mode);
    assign bus1.dut_sum  = r1[7:0];
    assign bus1.dut_cout = r1[8];
    assign bus2.dut_sum  = 8'h00;
    assign bus2.dut_cout = 1'b0;

    add_sub_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .uut(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_A(fa0), .fail_B(fb0), .fail_mode(fm0), .fail_sum(fs0)
    );

    add_sub_checker #(.SEED(8'h80)) u1 (
        .clk(clk), .rst(rst), .start(start1), .uut(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_A(fa1), .fail_B(fb1), .fail_mode(fm1), .fail_sum(fs1)
    );

    add_sub_checker #(.NUM_VEC(255), .SETTLE(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .uut(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_A(fa2), .fail_B(fb2), .fail_mode(fm2), .fail_sum(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_fail_zero(input string tag, input logic [7:0] fa,
                                   input logic [7:0] fb, input logic fm,
                                   input logic [8:0] fs);
        check_val({tag, "_fail_all"}, {fa, fb, fm, fs}, 32'h0);
    endtask

    // Full default-parameter run on u0; poke >= 0 pulses start mid-run.
    task automatic run0(input bit flip, input int poke);
        vec_t       e;
        logic [7:0] lf;
        logic [8:0] good;
        int         exp_err;
        sb.delete();
        for (int m = 0; m < 2; m++) begin
            lf = 8'h01;
            for (int v = 0; v < 16; v++) begin
                sb.push_back('{a: lf, b: {lf[3:0], lf[7:4]}, m: m[0]});
                lf = lfsr_step(lf);
            end
        end
        inj_flip = flip;
        exp_err  = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc == poke)     start0 = 1'b1;
            if (cyc == poke + 1) start0 = 1'b0;
            check_val("busy", {31'b0, busy0}, 32'd1);
            if (cyc % 2 == 0) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_val("vec_A", {24'b0, bus0.A}, {24'b0, e.a});
                    check_val("vec_B", {24'b0, bus0.B}, {24'b0, e.b});
                    check_val("vec_mode", {31'b0, bus0.mode}, {31'b0, e.m});
                    good = ref_unit(e.a, e.b, e.m);
                    if ((good ^ {8'b0, flip}) != good) exp_err++;
                end
            end
            if (cyc == 0) begin
                check_val("first_A", {24'b0, bus0.A}, 32'h01);
                check_val("first_B", {24'b0, bus0.B}, 32'h10);
                check_val("err_clr_on_start", {24'b0, err0}, 32'h0);
            end
            if (cyc == 2) begin
                check_val("second_A", {24'b0, bus0.A}, 32'h02);
                check_val("second_B", {24'b0, bus0.B}, 32'h20);
            end
            if (cyc == 32 && !flip) begin
                check_val("m1_first_vec", {15'b0, bus0.A, bus0.B, bus0.mode}, {15'b0, 8'h01, 8'h10, 1'b1});
                check_val("m1_first_res", {23'b0, bus0.dut_cout, bus0.dut_sum}, 32'h0F1);
            end
            @(negedge clk);
        end
        check_val("done_at_64", {31'b0, done0}, 32'd1);
        check_val("busy_at_64", {31'b0, busy0}, 32'd0);
        check_val("err_count", {24'b0, err0}, exp_err);
        check_val("pass", {31'b0, pass0}, {31'b0, (exp_err == 0)});
        check_val("mode_hold", {31'b0, bus0.mode}, 32'd1);
`ifdef ADD_SUB_CHK_CAPTURE_EN
        if (flip) begin
            check_val("fail_A", {24'b0, fa0}, 32'h01);
            check_val("fail_B", {24'b0, fb0}, 32'h10);
            check_val("fail_mode", {31'b0, fm0}, 32'd0);
            check_val("fail_sum", {23'b0, fs0}, 32'h011);
        end else begin
            check_fail_zero("u0", fa0, fb0, fm0, fs0);
        end
`else
        check_fail_zero("u0", fa0, fb0, fm0, fs0);
`endif
        inj_flip = 1'b0;
    endtask

    // Reset asserted during the subtract phase, between clock edges
    task automatic abort_mid();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (40) @(negedge clk);
        check_val("mid_mode1", {31'b0, bus0.mode}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check_val("async_rst_AB", {16'b0, bus0.A, bus0.B}, 32'h0);
        check_val("async_rst_mode", {31'b0, bus0.mode}, 32'd0);
        check_val("async_rst_idle", {29'b0, busy0, done0, pass0}, 32'd0);
        check_val("async_rst_err", {24'b0, err0}, 32'd0);
        check_fail_zero("async_rst", fa0, fb0, fm0, fs0);
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        logic [7:0] lf;
        int         n;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; inj_flip = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check_val("rst_AB", {16'b0, bus0.A, bus0.B}, 32'h0);
        check_val("rst_status", {29'b0, busy0, done0, pass0}, 32'd0);
        check_val("rst_err", {24'b0, err0}, 32'd0);
        check_fail_zero("rst", fa0, fb0, fm0, fs0);
        @(negedge clk); rst = 1'b0;

        run0(1'b0, 10);   // start pulsed while busy must be ignored
        run0(1'b1, -1);   // bit-0 fault on every vector
        run0(1'b0, -1);   // restart from DONE clears err_count
        abort_mid();
        run0(1'b0, -1);   // full pass after a mid-run reset

        // SEED = 8'h80 instance
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        check_val("s80_A", {24'b0, bus1.A}, 32'h80);
        check_val("s80_B", {24'b0, bus1.B}, 32'h08);
        repeat (32) @(negedge clk);
        check_val("s80_m1_vec", {15'b0, bus1.A, bus1.B, bus1.mode}, {15'b0, 8'h80, 8'h08, 1'b1});
        check_val("s80_m1_res", {23'b0, bus1.dut_cout, bus1.dut_sum}, 32'h178);
        n = 0;
        while (!done1 && n < 100) begin @(negedge clk); n++; end
        check_val("s80_done", {31'b0, done1}, 32'd1);
        check_val("s80_pass", {31'b0, pass1}, 32'd1);
        check_val("s80_err", {24'b0, err1}, 32'd0);
        check_fail_zero("u1", fa1, fb1, fm1, fs1);

        // NUM_VEC = 255 with stuck-at-zero unit
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        n = 0;
        while (!done2 && n < 1100) begin
            @(negedge clk); n++;
            if (n == 700) check_val("sat_mid", {24'b0, err2}, 32'hFF);
        end
        check_val("sat_done", {31'b0, done2}, 32'd1);
        check_val("sat_cycles", n, 32'd1020);
        check_val("sat_err", {24'b0, err2}, 32'hFF);
        check_val("sat_pass", {31'b0, pass2}, 32'd0);
        lf = 8'h01;
        for (int i = 0; i < 254; i++) lf = lfsr_step(lf);
        check_val("sat_hold", {15'b0, bus2.A, bus2.B, bus2.mode}, {15'b0, lf, lf[3:0], lf[7:4], 1'b1});
`ifdef ADD_SUB_CHK_CAPTURE_EN
        check_val("sat_fail", {fa2, fb2, fm2, fs2[6:0]}, {8'h01, 8'h10, 1'b0, 7'h11});
        check_val("sat_fail_hi", {30'b0, fs2[8:7]}, 32'd0);
`else
        check_fail_zero("u2", fa2, fb2, fm2, fs2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/add_sub_checker.md
ADD_SUB_CHECKER -- requirements
Module: add_sub_checker

Interface
REQ-001 Parameter NUM_VEC, 16, vectors per mode phase (1..255).
REQ-002 Parameter SEED, 8'h01, LFSR seed; nonzero.
REQ-003 Parameter SETTLE, 1, cycles operands are held before the result is checked (1..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE or DONE.
REQ-007 dut_sum  input  8  sum from the adder/subtractor under test.
REQ-008 dut_cout  input  1  carry/borrow-not from the unit under test.
REQ-009 A, B  output  8 each  registered operands driven to the unit under test.
REQ-010 mode  output  1  0 = add, 1 = subtract; registered.
REQ-011 busy  output  1  high in DRIVE or CHECK.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  done && err_count == 0.
REQ-014 err_count  output  8  mismatch count, saturating at 8'hFF.
REQ-015 fail_A, fail_B  output  8 each; fail_mode  output  1; fail_sum  output  9: first-failure capture (see Configuration).

Function
REQ-016 The FSM SHALL have four states: IDLE, DRIVE, CHECK, DONE.
REQ-017 In IDLE or DONE, start=1 SHALL load the LFSR with SEED, set mode=0, clear the vector index, settle counter and err_count, and enter DRIVE on the next edge.
REQ-018 In DRIVE, A SHALL equal the LFSR value, and B SHALL equal {LFSR[3:0],LFSR[7:4]}; after SETTLE cycles the FSM SHALL enter CHECK.
REQ-019 Expected value for mode 0 SHALL be the 9-bit {cout,sum} = A + B.
REQ-020 Expected value for mode 1 SHALL be A + ~B + 1 in 9 bits: sum = (A - B) mod 256, cout = 1 iff A >= B.
REQ-021 In CHECK (one cycle), the block SHALL compare {dut_cout,dut_sum} to the expected value; on mismatch it SHALL increment err_count unless err_count is 8'hFF.
REQ-022 After CHECK the LFSR SHALL advance: next = {q[6:0], q[7]^q[5]^q[4]^q[3]} (x^8+x^6+x^5+x^4+1).
REQ-023 After CHECK the index SHALL increment, and the FSM SHALL return to DRIVE.
REQ-024 After the NUM_VEC-th check with mode=0, the block SHALL set mode=1, reload the LFSR with SEED, clear the index, and return to DRIVE.
REQ-025 After the NUM_VEC-th check with mode=1, the FSM SHALL enter DONE.
REQ-026 A run SHALL take exactly 2*NUM_VEC*(SETTLE+1) cycles from the first DRIVE cycle to DONE.
REQ-027 start while busy SHALL be ignored.
REQ-028 start in DONE SHALL restart the run per REQ-017.
REQ-029 A, B, mode and err_count SHALL hold their last values in DONE.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, regardless of clock, including mid-run.
REQ-031 rst=1 SHALL clear A, B, mode, busy, done, pass, err_count, and all fail_* outputs to 0, and load the LFSR with SEED.

Configuration
REQ-032 Macro ADD_SUB_CHK_CAPTURE_EN: when defined, the first mismatch of a run SHALL latch A, B, mode and the expected {cout,sum} into fail_A, fail_B, fail_mode and fail_sum.
REQ-033 Under ADD_SUB_CHK_CAPTURE_EN, the latched fail_* values SHALL hold until the next start or rst.
REQ-034 When ADD_SUB_CHK_CAPTURE_EN is undefined, fail_* SHALL be constant 0 and no capture registers SHALL exist.

Verification
REQ-035 The bench SHALL connect a correct adder/subtractor model, use defaults, and pulse start -> first DRIVE has A=8'h01, B=8'h10, mode=0, then second vector has A=8'h02, B=8'h20; done after 64 cycles, pass=1, err_count=0.
REQ-036 The bench SHALL check mode-1 first vector: A=8'h01, B=8'h10 -> expected sum=8'hF1, cout=0; with SEED=8'h80 -> A=8'h80, B=8'h08, sum=8'h78, cout=1.
REQ-037 The bench SHALL force dut_sum bit 0 to be inverted on all vectors -> err_count=32 at done, pass=0; with capture enabled, fail_A=8'h01, fail_B=8'h10, fail_mode=0, fail_sum=9'h011.
REQ-038 The bench SHALL use NUM_VEC=255, SETTLE=1, and a stuck-at-0 dut_sum -> err_count saturates at 8'hFF and does not wrap.
REQ-039 The bench SHALL assert rst mid-run (during the mode=1 phase) -> outputs go to 0 and the state is IDLE without a clock edge; a following start runs a full 64-cycle pass.
REQ-040 The bench SHALL pulse start while busy -> no restart and unchanged timing; start in DONE -> err_count clears and a new run begins.
